// File: rtl/sha2_core_if.sv
// sha2_core_if: request/response bundle between the host framing logic and the SHA-2 engine
interface sha2_core_if #(parameter int WORD = 32);
  logic [16*WORD-1:0] Data;
  logic First;
  logic [1:0] Operation;
  logic Enable;
  logic Busy;
  logic Valid;
  logic [8*WORD-1:0] Hash;
  modport master(output Data, First, Operation, Enable, input Busy, Valid, Hash);
  modport slave(input Data, First, Operation, Enable, output Busy, Valid, Hash);
endinterface

// File: rtl/sha2_core.sv
// sha2_core: one-round-per-cycle SHA-2 compression engine for 32-bit or 64-bit words
module sha2_core #(parameter int WORD = 32) (
  input logic clk,
  input logic rst,
  sha2_core_if.slave bus
);
  if (WORD != 32 && WORD != 64) begin : g_bad_word
    $error("sha2_core: WORD must be 32 or 64");
  end
  localparam bit W64 = (WORD == 64);
  localparam logic [6:0] LAST = W64 ? 7'd79 : 7'd63;
  localparam int BS0A = W64 ? 28 : 2;
  localparam int BS0B = W64 ? 34 : 13;
  localparam int BS0C = W64 ? 39 : 22;
  localparam int BS1A = W64 ? 14 : 6;
  localparam int BS1B = W64 ? 18 : 11;
  localparam int BS1C = W64 ? 41 : 25;
  localparam int SS0A = W64 ? 1 : 7;
  localparam int SS0B = W64 ? 8 : 18;
  localparam int SS0C = W64 ? 7 : 3;
  localparam int SS1A = W64 ? 19 : 17;
  localparam int SS1B = W64 ? 61 : 19;
  localparam int SS1C = W64 ? 6 : 10;
  // SHA-256 round constants are the upper halves of the SHA-512 ones
  localparam logic [63:0] K [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};
  localparam logic [31:0] IV32 [2][8] = '{
    '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4},
    '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19}};
  localparam logic [63:0] IV64 [4][8] = '{
    '{64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
      64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4},
    '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179},
    '{64'h8c3d37c819544da2, 64'h73e1996689dcd4d6, 64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
      64'h0f6d2b697bd44da8, 64'h77e36f7304c48942, 64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1},
    '{64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2, 64'h2393b86b6f53b151, 64'h963877195940eabd,
      64'h96283ee2a88effe3, 64'hbe5e1e2553863992, 64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2}};
  typedef enum logic {IDLE, ROUND} state_e;
  state_e state_q, state_d;
  logic [6:0] t_q, t_d;
  logic [1:0] mode_q, mode_d;
  logic valid_q, valid_d;
  logic [WORD-1:0] h_q [8], h_d [8], v_q [8], v_d [8], w_q [16], w_d [16];
  logic [WORD-1:0] wt, t1, t2;
  logic [63:0] k64;
  function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] x, input int n);
    return (x >> n) | (x << (WORD - n));
  endfunction
  function automatic logic [WORD-1:0] bsig0(input logic [WORD-1:0] x);
    return rotr(x, BS0A) ^ rotr(x, BS0B) ^ rotr(x, BS0C);
  endfunction
  function automatic logic [WORD-1:0] bsig1(input logic [WORD-1:0] x);
    return rotr(x, BS1A) ^ rotr(x, BS1B) ^ rotr(x, BS1C);
  endfunction
  function automatic logic [WORD-1:0] ssig0(input logic [WORD-1:0] x);
    return rotr(x, SS0A) ^ rotr(x, SS0B) ^ (x >> SS0C);
  endfunction
  function automatic logic [WORD-1:0] ssig1(input logic [WORD-1:0] x);
    return rotr(x, SS1A) ^ rotr(x, SS1B) ^ (x >> SS1C);
  endfunction
  function automatic logic [WORD-1:0] iv(input logic [1:0] m, input int i);
    return W64 ? WORD'(IV64[m][i]) : WORD'(IV32[m != 2'd0][i]);
  endfunction
  assign k64 = K[t_q];
  assign wt = (t_q < 7'd16) ? w_q[t_q[3:0]]
            : ssig1(w_q[t_q[3:0] - 4'd2]) + w_q[t_q[3:0] - 4'd7]
              + ssig0(w_q[t_q[3:0] - 4'd15]) + w_q[t_q[3:0]];
  assign t1 = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
            + WORD'(W64 ? k64 : k64 >> 32) + wt;
  assign t2 = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    mode_d = mode_q;
    valid_d = 1'b0;
    h_d = h_q;
    v_d = v_q;
    w_d = w_q;
    if (state_q == IDLE) begin
      if (bus.Enable) begin
        state_d = ROUND;
        t_d = '0;
        for (int i = 0; i < 16; i++) w_d[i] = bus.Data[i*WORD +: WORD];
        mode_d = bus.First ? bus.Operation : mode_q;
        for (int i = 0; i < 8; i++) begin
          h_d[i] = bus.First ? iv(mode_d, i) : h_q[i];
          v_d[i] = h_d[i];
        end
      end
    end else begin
      w_d[t_q[3:0]] = wt;
      v_d = '{t1 + t2, v_q[0], v_q[1], v_q[2], v_q[3] + t1, v_q[4], v_q[5], v_q[6]};
      t_d = t_q + 7'd1;
      if (t_q == LAST) begin
        state_d = IDLE;
        valid_d = 1'b1;
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_d[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q <= '0;
      mode_q <= '0;
      valid_q <= 1'b0;
      h_q <= '{default: '0};
      v_q <= '{default: '0};
      w_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      mode_q <= mode_d;
      valid_q <= valid_d;
      h_q <= h_d;
      v_q <= v_d;
      w_q <= w_d;
    end
  end
  assign bus.Busy = (state_q == ROUND);
  assign bus.Valid = valid_q;
  for (genvar i = 0; i < 8; i++) begin : g_hash
    assign bus.Hash[(7-i)*WORD +: WORD] = h_q[i];
  end
endmodule

// File: tb/tb_sha2_core.sv
// tb_sha2_core: directed known-answer checks for the 32-bit and 64-bit SHA-2 engines
module tb_sha2_core;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  sha2_core_if #(.WORD(32)) b32();
  sha2_core_if #(.WORD(64)) b64();
  sha2_core #(.WORD(32)) dut32(.clk(clk), .rst(rst), .bus(b32));
  sha2_core #(.WORD(64)) dut64(.clk(clk), .rst(rst), .bus(b64));
  localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [223:0] ABC224 = 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
  localparam logic [255:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC512 = {256'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a,
                                     256'h2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f};
  localparam logic [31:0] MSG [14] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
    32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
  function automatic logic [511:0] abc32();
    logic [511:0] d = '0;
    d[31:0] = 32'h61626380;
    d[15*32 +: 32] = 32'h18;
    return d;
  endfunction
  task automatic send32(input logic [511:0] d, input logic f, input logic [1:0] op);
    b32.Data = d;
    b32.First = f;
    b32.Operation = op;
    b32.Enable = 1'b1;
    @(posedge clk);
    #1;
    b32.Enable = 1'b0;
  endtask
  task automatic wait_valid(input bit w64, output int cyc);
    cyc = 1;
    while ((w64 ? b64.Valid : b32.Valid) !== 1'b1 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (b32.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy32: got %b want 0", b32.Busy); end
    total++; if (b32.Valid !== 1'b0) begin bad++; $display("FAIL reset_valid32: got %b want 0", b32.Valid); end
    total++; if (b32.Hash !== '0) begin bad++; $display("FAIL reset_hash32: got %h want 0", b32.Hash); end
    total++; if (b64.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy64: got %b want 0", b64.Busy); end
    total++; if (b64.Valid !== 1'b0) begin bad++; $display("FAIL reset_valid64: got %b want 0", b64.Valid); end
    total++; if (b64.Hash !== '0) begin bad++; $display("FAIL reset_hash64: got %h want 0", b64.Hash); end
    rst = 1'b0;
  endtask
  task automatic test_sha256_abc();
    int cyc;
    send32(abc32(), 1'b1, 2'd1);
    total++; if (b32.Busy !== 1'b1) begin bad++; $display("FAIL sha256_busy: got %b want 1", b32.Busy); end
    wait_valid(1'b0, cyc);
    total++; if (cyc != 65) begin bad++; $display("FAIL sha256_latency: got %0d want 65", cyc); end
    total++; if (b32.Busy !== 1'b0) begin bad++; $display("FAIL sha256_busy_done: got %b want 0", b32.Busy); end
    total++; if (b32.Hash !== ABC256) begin bad++; $display("FAIL sha256_hash: got %h want %h", b32.Hash, ABC256); end
    @(posedge clk);
    #1;
    total++; if (b32.Valid !== 1'b0) begin bad++; $display("FAIL sha256_valid_width: got %b want 0", b32.Valid); end
    total++; if (b32.Hash !== ABC256) begin bad++; $display("FAIL sha256_hash_hold: got %h want %h", b32.Hash, ABC256); end
  endtask
  task automatic test_sha224_abc();
    int cyc;
    send32(abc32(), 1'b1, 2'd0);
    wait_valid(1'b0, cyc);
    total++; if (cyc != 65) begin bad++; $display("FAIL sha224_latency: got %0d want 65", cyc); end
    total++; if (b32.Hash[255:32] !== ABC224) begin bad++; $display("FAIL sha224_hash: got %h want %h", b32.Hash[255:32], ABC224); end
  endtask
  task automatic test_back_to_back();
    int cyc;
    logic [511:0] d = '0;
    for (int i = 0; i < 14; i++) d[i*32 +: 32] = MSG[i];
    d[14*32 +: 32] = 32'h80000000;
    send32(d, 1'b1, 2'd1);
    wait_valid(1'b0, cyc);
    total++; if (cyc != 65) begin bad++; $display("FAIL two_block_lat1: got %0d want 65", cyc); end
    d = '0;
    d[15*32 +: 32] = 32'h1c0;
    send32(d, 1'b0, 2'd0);
    total++; if (b32.Busy !== 1'b1) begin bad++; $display("FAIL two_block_accept: got busy %b want 1", b32.Busy); end
    wait_valid(1'b0, cyc);
    total++; if (cyc != 65) begin bad++; $display("FAIL two_block_lat2: got %0d want 65", cyc); end
    total++; if (b32.Hash !== TWO256) begin bad++; $display("FAIL two_block_hash: got %h want %h", b32.Hash, TWO256); end
  endtask
  task automatic test_sha512_abc();
    int cyc;
    logic [1023:0] d = '0;
    d[63:0] = 64'h6162638000000000;
    d[15*64 +: 64] = 64'h18;
    b64.Data = d;
    b64.First = 1'b1;
    b64.Operation = 2'd1;
    b64.Enable = 1'b1;
    @(posedge clk);
    #1;
    b64.Enable = 1'b0;
    total++; if (b64.Busy !== 1'b1) begin bad++; $display("FAIL sha512_busy: got %b want 1", b64.Busy); end
    wait_valid(1'b1, cyc);
    total++; if (cyc != 81) begin bad++; $display("FAIL sha512_latency: got %0d want 81", cyc); end
    total++; if (b64.Hash !== ABC512) begin bad++; $display("FAIL sha512_hash: got %h want %h", b64.Hash, ABC512); end
  endtask
  task automatic test_enable_busy();
    int pulses = 0;
    send32(abc32(), 1'b1, 2'd1);
    for (int c = 1; c <= 64; c++) begin
      pulses += int'(b32.Valid);
      b32.Enable = c[0];
      b32.Data = {16{$urandom}};
      b32.First = 1'($urandom);
      b32.Operation = 2'($urandom);
      @(posedge clk);
      #1;
    end
    b32.Enable = 1'b0;
    total++; if (b32.Valid !== 1'b1) begin bad++; $display("FAIL busy_valid_cycle: got %b want 1", b32.Valid); end
    total++; if (b32.Hash !== ABC256) begin bad++; $display("FAIL busy_hash: got %h want %h", b32.Hash, ABC256); end
    for (int c = 0; c < 6; c++) begin
      pulses += int'(b32.Valid);
      @(posedge clk);
      #1;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL busy_pulses: got %0d want 1", pulses); end
    total++; if (b32.Busy !== 1'b0) begin bad++; $display("FAIL busy_no_queue: got %b want 0", b32.Busy); end
  endtask
  task automatic test_reset_mid();
    int cyc;
    send32(abc32(), 1'b1, 2'd1);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (b32.Busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b want 0", b32.Busy); end
    total++; if (b32.Valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", b32.Valid); end
    total++; if (b32.Hash !== '0) begin bad++; $display("FAIL mid_reset_hash: got %h want 0", b32.Hash); end
    send32(abc32(), 1'b1, 2'd1);
    wait_valid(1'b0, cyc);
    total++; if (cyc != 65) begin bad++; $display("FAIL mid_reset_latency: got %0d want 65", cyc); end
    total++; if (b32.Hash !== ABC256) begin bad++; $display("FAIL mid_reset_rerun: got %h want %h", b32.Hash, ABC256); end
  endtask
  initial begin
    rst = 1'b1;
    b32.Enable = 1'b0;
    b32.First = 1'b0;
    b32.Operation = 2'd0;
    b32.Data = '0;
    b64.Enable = 1'b0;
    b64.First = 1'b0;
    b64.Operation = 2'd0;
    b64.Data = '0;
    test_reset();
    test_sha256_abc();
    test_sha224_abc();
    test_back_to_back();
    test_sha512_abc();
    test_enable_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
